// File: rtl/lcd_char_if_engine.sv
// ---------------------------------------------------------------------------
// lcd_char_if_engine
//
// Write-only HD44780 character-LCD driver in 8-bit mode. After reset it waits
// for the panel to power up and plays the six-entry init ROM on its own. It
// then accepts instruction/data bytes from the register file, one at a time,
// and turns each one into a SETUP / E-high / HOLD / EXEC write cycle.
//
// Ports
//   ACLK, ARESETN       clock; synchronous active-low reset
//   cmd_valid/cmd_ready byte handshake from the register file
//   cmd_rs, cmd_data    0 = instruction, 1 = data; byte to write
//   busy                engine not idle (readback)
//   init_done           power-on init finished (sticky until reset)
//   lcd_e/rs/rw/db      panel bus; rw is tied low
//
// Every output comes from a flop. Each flop is loaded from the next-state
// decode, so lcd_e, cmd_ready and busy line up exactly with the state they
// describe and no input reaches an output without passing through a flop.
// ---------------------------------------------------------------------------
module lcd_char_if_engine #(
  parameter int T_POWERUP   = 1500000,
  parameter int T_SETUP     = 5,
  parameter int T_EPW       = 25,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 4000,
  parameter int T_EXEC_LONG = 164000,
  parameter int CNT_W       = 21
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT_LOAD,
    S_SETUP,
    S_EHIGH,
    S_HOLD,
    S_EXEC,
    S_IDLE
  } state_t;

  localparam logic [2:0] INIT_LAST = 3'd5;

  // Terminal counts: a phase of T cycles ends when the counter reads T-1.
  localparam logic [CNT_W-1:0] L_PWRUP  = CNT_W'(T_POWERUP - 1);
  localparam logic [CNT_W-1:0] L_SETUP  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] L_EPW    = CNT_W'(T_EPW - 1);
  localparam logic [CNT_W-1:0] L_HOLD   = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] L_EXEC   = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] L_EXEC_L = CNT_W'(T_EXEC_LONG - 1);

  // HD44780 8-bit init: function set x3, display on, clear, entry mode.
  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = 8'h38;
      3'd3:             init_rom = 8'h0C;
      3'd4:             init_rom = 8'h01;
      3'd5:             init_rom = 8'h06;
      default:          init_rom = 8'h00;
    endcase
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic             r_rs;
  logic [7:0]       r_db;
  logic             r_e;
  logic             r_ready;
  logic             r_busy;
  logic             r_init_done;

  state_t           w_nxt_state;
  logic [2:0]       w_nxt_idx;
  logic             w_nxt_rs;
  logic [7:0]       w_nxt_db;
  logic             w_nxt_done;
  logic [CNT_W-1:0] w_lim;
  logic             w_cnt_hit;
  logic             w_long;
  logic             w_hs;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  // Data writes are always short, whatever their value.
  assign w_long = ~r_rs & (r_db[7:2] == 6'd0);

  // cmd_ready is only high in IDLE, so this is the IDLE handshake.
  assign w_hs = cmd_valid & r_ready;

  always_comb begin
    w_lim = '0;
    case (r_state)
      S_PWRUP: w_lim = L_PWRUP;
      S_SETUP: w_lim = L_SETUP;
      S_EHIGH: w_lim = L_EPW;
      S_HOLD:  w_lim = L_HOLD;
      S_EXEC:  w_lim = w_long ? L_EXEC_L : L_EXEC;
      default: w_lim = '0;
    endcase
  end

  assign w_cnt_hit = (r_cnt == w_lim);

  // Next-state and datapath decode.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_rs    = r_rs;
    w_nxt_db    = r_db;
    w_nxt_done  = r_init_done;
    case (r_state)
      S_PWRUP: begin
        if (w_cnt_hit) begin
          w_nxt_state = S_INIT_LOAD;
          w_nxt_idx   = 3'd0;
        end
      end
      S_INIT_LOAD: begin
        // Single-cycle state; the ROM byte is loaded as SETUP begins.
        w_nxt_rs    = 1'b0;
        w_nxt_db    = init_rom(r_idx);
        w_nxt_state = S_SETUP;
      end
      S_IDLE: begin
        if (w_hs) begin
          w_nxt_rs    = cmd_rs;
          w_nxt_db    = cmd_data;
          w_nxt_state = S_SETUP;
        end
      end
      S_SETUP: if (w_cnt_hit) w_nxt_state = S_EHIGH;
      S_EHIGH: if (w_cnt_hit) w_nxt_state = S_HOLD;
      S_HOLD:  if (w_cnt_hit) w_nxt_state = S_EXEC;
      S_EXEC: begin
        if (w_cnt_hit) begin
          if (!r_init_done && (r_idx != INIT_LAST)) begin
            w_nxt_idx   = r_idx + 3'd1;
            w_nxt_state = S_INIT_LOAD;
          end else begin
            // Reaching here during init means the last ROM entry just retired.
            w_nxt_done  = 1'b1;
            w_nxt_state = S_IDLE;
          end
        end
      end
      default: w_nxt_state = S_PWRUP;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state     <= S_PWRUP;
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_rs        <= 1'b0;
      r_db        <= 8'h00;
      r_e         <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b1;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      // The counter restarts on every state change, so cycle one of a
      // state sees 0. IDLE has no timeout, so the counter stays at 0 there.
      if ((w_nxt_state != r_state) || (r_state == S_IDLE))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      r_idx       <= w_nxt_idx;
      r_rs        <= w_nxt_rs;
      r_db        <= w_nxt_db;
      r_e         <= (w_nxt_state == S_EHIGH);
      r_ready     <= (w_nxt_state == S_IDLE);
      r_busy      <= (w_nxt_state != S_IDLE);
      r_init_done <= w_nxt_done;
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign init_done = r_init_done;
  assign lcd_e     = r_e;
  assign lcd_rs    = r_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_db    = r_db;

endmodule

// File: tb/tb_lcd_char_if_engine.sv
module tb_lcd_char_if_engine;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, busy, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;

  lcd_char_if_engine #(
    .T_POWERUP(100), .T_SETUP(2), .T_EPW(4), .T_HOLD(1),
    .T_EXEC(20), .T_EXEC_LONG(50), .CNT_W(21)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data),
    .busy(busy), .init_done(init_done),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
  );

  always #5 ACLK = ~ACLK;

  int pass_cnt = 0;
  int total_cnt = 0;

  // cyc = number of rising edges so far; stable by the falling edge.
  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // E-pulse log: rise edge number with RS/DB at that point, and fall edge.
  int         rise_q[$];
  int         fall_q[$];
  logic [7:0] db_q[$];
  logic       rs_q[$];
  logic       prev_e = 1'b0;
  always @(negedge ACLK) begin
    if (lcd_e === 1'b1 && prev_e === 1'b0) begin
      rise_q.push_back(cyc);
      db_q.push_back(lcd_db);
      rs_q.push_back(lcd_rs);
    end
    if (lcd_e === 1'b0 && prev_e === 1'b1) fall_q.push_back(cyc);
    prev_e = lcd_e;
  end

  logic [7:0] exp_rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  // Inputs are driven and outputs sampled just after the falling edge.
  task automatic nstep;
    @(negedge ACLK);
    #1;
  endtask

  task automatic wait_ready;
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 1000) begin nstep; n++; end
  endtask

  // Stimulus only: one handshake, then return handshake edge and latency.
  task automatic send(input logic rs, input logic [7:0] d, output int h, output int lat);
    int n;
    wait_ready;
    cmd_valid = 1'b1; cmd_rs = rs; cmd_data = d;
    nstep;
    h = cyc;
    cmd_valid = 1'b0;
    lat = -1;
    n = 0;
    while (n < 1000) begin
      nstep; n++;
      if (cmd_ready === 1'b1) begin lat = cyc - h; break; end
    end
  endtask

  task automatic test_reset;
    ARESETN = 1'b0;
    repeat (3) nstep;
    total_cnt++; if (lcd_e !== 1'b0) $display("FAIL reset_e: got %b want 0", lcd_e); else pass_cnt++;
    total_cnt++; if (lcd_rs !== 1'b0) $display("FAIL reset_rs: got %b want 0", lcd_rs); else pass_cnt++;
    total_cnt++; if (lcd_rw !== 1'b0) $display("FAIL reset_rw: got %b want 0", lcd_rw); else pass_cnt++;
    total_cnt++; if (lcd_db !== 8'h00) $display("FAIL reset_db: got %h want 00", lcd_db); else pass_cnt++;
    total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", cmd_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (init_done !== 1'b0) $display("FAIL reset_init_done: got %b want 0", init_done); else pass_cnt++;
  endtask

  // Releases reset on the coming edge and checks the whole init replay.
  task automatic test_init(input string tag);
    int rb, fb, c0, viol, done_c, n;
    logic rdy;
    rb = rise_q.size(); fb = fall_q.size();
    c0 = cyc; viol = 0; done_c = -1; rdy = 1'b0;
    ARESETN = 1'b1;
    n = 0;
    while (n < 3000) begin
      nstep; n++;
      if (cmd_ready === 1'b1 && init_done !== 1'b1) viol++;
      if (lcd_rw !== 1'b0) viol++;
      if (init_done === 1'b1) begin done_c = cyc; rdy = cmd_ready; break; end
    end
    repeat (40) nstep;
    total_cnt++; if (done_c < 0) $display("FAIL %s_timeout: init_done never rose", tag); else pass_cnt++;
    total_cnt++; if (viol != 0) $display("FAIL %s_early_ready: %0d bad cycles want 0", tag, viol); else pass_cnt++;
    total_cnt++; if (rise_q.size() - rb != 6) $display("FAIL %s_pulse_count: got %0d want 6", tag, rise_q.size() - rb); else pass_cnt++;
    total_cnt++; if (fall_q.size() - fb != 6) $display("FAIL %s_fall_count: got %0d want 6", tag, fall_q.size() - fb); else pass_cnt++;
    if (rise_q.size() - rb == 6 && fall_q.size() - fb == 6) begin
      total_cnt++;
      if (rise_q[rb] != c0 + 103) $display("FAIL %s_first_rise: got edge %0d want %0d", tag, rise_q[rb], c0 + 103); else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
        total_cnt++;
        if (db_q[rb+i] !== exp_rom[i] || rs_q[rb+i] !== 1'b0)
          $display("FAIL %s_byte%0d: got rs=%b db=%h want rs=0 db=%h", tag, i, rs_q[rb+i], db_q[rb+i], exp_rom[i]);
        else pass_cnt++;
        total_cnt++;
        if (fall_q[fb+i] - rise_q[rb+i] != 4)
          $display("FAIL %s_width%0d: got %0d want 4", tag, i, fall_q[fb+i] - rise_q[rb+i]);
        else pass_cnt++;
      end
      for (int i = 0; i < 5; i++) begin
        total_cnt++;
        if (rise_q[rb+i+1] - fall_q[fb+i] != ((i == 4) ? 54 : 24))
          $display("FAIL %s_gap%0d: got %0d want %0d", tag, i, rise_q[rb+i+1] - fall_q[fb+i], (i == 4) ? 54 : 24);
        else pass_cnt++;
      end
      total_cnt++;
      if (done_c != fall_q[fb+5] + 21) $display("FAIL %s_done_edge: got %0d want %0d", tag, done_c, fall_q[fb+5] + 21); else pass_cnt++;
    end
    total_cnt++; if (rdy !== 1'b1) $display("FAIL %s_ready_with_done: got %b want 1", tag, rdy); else pass_cnt++;
  endtask

  task automatic test_data_write;
    int rb, h, lat, n;
    wait_ready;
    rb = rise_q.size();
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h41;
    nstep;
    h = cyc;
    cmd_valid = 1'b0;
    total_cnt++; if (cmd_ready !== 1'b0 || busy !== 1'b1) $display("FAIL wr_after_hs: got ready=%b busy=%b want 0/1", cmd_ready, busy); else pass_cnt++;
    total_cnt++; if (lcd_rs !== 1'b1 || lcd_db !== 8'h41 || lcd_e !== 1'b0) $display("FAIL wr_bus: got rs=%b db=%h e=%b want 1/41/0", lcd_rs, lcd_db, lcd_e); else pass_cnt++;
    lat = -1; n = 0;
    while (n < 1000) begin
      nstep; n++;
      if (cmd_ready === 1'b1) begin lat = cyc - h; break; end
    end
    total_cnt++; if (lat != 27) $display("FAIL wr_latency: got %0d want 27", lat); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL wr_busy_idle: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (lcd_db !== 8'h41 || lcd_rs !== 1'b1) $display("FAIL wr_bus_held: got rs=%b db=%h want 1/41", lcd_rs, lcd_db); else pass_cnt++;
    total_cnt++;
    if (rise_q.size() - rb != 1) $display("FAIL wr_pulses: got %0d want 1", rise_q.size() - rb);
    else if (rise_q[rb] != h + 2 || fall_q[fall_q.size()-1] - rise_q[rb] != 4)
      $display("FAIL wr_e_timing: got rise +%0d width %0d want +2 width 4", rise_q[rb] - h, fall_q[fall_q.size()-1] - rise_q[rb]);
    else pass_cnt++;
  endtask

  task automatic test_instr_timing;
    logic       t_rs  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] t_d   [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h80, 8'h01};
    int         t_lat [6] = '{57, 57, 57, 27, 27, 27};
    int h, lat;
    for (int i = 0; i < 6; i++) begin
      send(t_rs[i], t_d[i], h, lat);
      total_cnt++;
      if (lat != t_lat[i]) $display("FAIL instr_lat rs=%b d=%h: got %0d want %0d", t_rs[i], t_d[i], lat, t_lat[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    int rb, h1, r1, h2, n;
    wait_ready;
    rb = rise_q.size();
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h48;
    nstep;
    h1 = cyc;
    total_cnt++; if (cmd_ready !== 1'b0 || lcd_db !== 8'h48) $display("FAIL b2b_first: got ready=%b db=%h want 0/48", cmd_ready, lcd_db); else pass_cnt++;
    cmd_data = 8'h49;
    r1 = -1; n = 0;
    while (n < 1000) begin
      nstep; n++;
      if (cmd_ready === 1'b1) begin r1 = cyc; break; end
    end
    nstep;
    h2 = cyc;
    total_cnt++; if (cmd_ready !== 1'b0 || lcd_db !== 8'h49) $display("FAIL b2b_second: got ready=%b db=%h want 0/49", cmd_ready, lcd_db); else pass_cnt++;
    cmd_valid = 1'b0;
    total_cnt++; if (r1 != h1 + 27) $display("FAIL b2b_ready_edge: got +%0d want +27", r1 - h1); else pass_cnt++;
    total_cnt++; if (h2 != r1 + 1) $display("FAIL b2b_hs2_edge: got +%0d want +1", h2 - r1); else pass_cnt++;
    wait_ready;
    repeat (40) nstep;
    total_cnt++;
    if (rise_q.size() - rb != 2) $display("FAIL b2b_count: got %0d pulses want 2", rise_q.size() - rb);
    else if (db_q[rb] !== 8'h48 || db_q[rb+1] !== 8'h49) $display("FAIL b2b_order: got %h,%h want 48,49", db_q[rb], db_q[rb+1]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_pulse;
    int h, r, n;
    wait_ready;
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h33;
    nstep;
    h = cyc;
    cmd_valid = 1'b0;
    r = -1; n = 0;
    while (n < 100) begin
      nstep; n++;
      if (lcd_e === 1'b1) begin r = cyc; break; end
    end
    total_cnt++; if (r != h + 2) $display("FAIL mid_rise: got +%0d want +2", r - h); else pass_cnt++;
    nstep; nstep;
    ARESETN = 1'b0;       // sampled at the edge ending the 3rd E-high cycle
    nstep;
    total_cnt++;
    if (lcd_e !== 1'b0 || busy !== 1'b1 || init_done !== 1'b0 || lcd_db !== 8'h00 || cmd_ready !== 1'b0 || lcd_rs !== 1'b0)
      $display("FAIL mid_reset: got e=%b busy=%b done=%b db=%h ready=%b rs=%b want 0/1/0/00/0/0",
               lcd_e, busy, init_done, lcd_db, cmd_ready, lcd_rs);
    else pass_cnt++;
    test_init("replay");
  endtask

  task automatic test_held_valid;
    int rb, viol, done_c, n, pre;
    ARESETN = 1'b0;
    nstep; nstep;
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h55;
    rb = rise_q.size();
    ARESETN = 1'b1;
    viol = 0; done_c = -1; n = 0; pre = -1;
    while (n < 3000) begin
      nstep; n++;
      if (cmd_ready === 1'b1 && init_done !== 1'b1) viol++;
      if (init_done === 1'b1) begin done_c = cyc; pre = rise_q.size() - rb; break; end
    end
    total_cnt++; if (done_c < 0) $display("FAIL held_timeout: init_done never rose"); else pass_cnt++;
    total_cnt++; if (viol != 0 || pre != 6) $display("FAIL held_early: got %0d bad cycles, %0d pulses want 0, 6", viol, pre); else pass_cnt++;
    nstep;
    total_cnt++;
    if (cmd_ready !== 1'b0 || lcd_db !== 8'h55 || lcd_rs !== 1'b1)
      $display("FAIL held_accept: got ready=%b db=%h rs=%b want 0/55/1", cmd_ready, lcd_db, lcd_rs);
    else pass_cnt++;
    cmd_valid = 1'b0;
    wait_ready;
    total_cnt++;
    if (rise_q.size() - rb != 7) $display("FAIL held_count: got %0d pulses want 7", rise_q.size() - rb);
    else if (db_q[rb+5] !== 8'h06 || db_q[rb+6] !== 8'h55 || rise_q[rb+6] != done_c + 3)
      $display("FAIL held_order: got %h,%h at +%0d want 06,55 at +3", db_q[rb+5], db_q[rb+6], rise_q[rb+6] - done_c);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_init("init");
    test_data_write;
    test_instr_timing;
    test_back_to_back;
    test_reset_mid_pulse;
    test_held_valid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
